pipe_stage_reg: RTL and testbench

//  - Parametrised pipeline stage register; successor to the fixed-width stall registers.
//  - Carries a WIDTH-bit payload plus a valid bit, with:
//    - a valid/ready handshake,
//    - a stall hold,
//    - a flush that inserts a bubble (BUBBLE_VAL, e.g. a NOP).
//  - Sits between CPU pipeline stages (IF/ID, ID/EX, ...) and on the UART TX/RX data paths.
//

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_skid_slot.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Used by stage registers and the hazard unit.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry skid slot: WIDTH payload + valid.
// Ports: clk, rst, clear, load, unload, load_data -> valid, data.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready, stall hold, flush bubble.
// Ports: clk, rst, stall, flush, in_*/out_* handshakes; PIPE_STAGE_SKID_EN adds skid.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  pipe_ctrl_t       ctrl;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             adv;

  assign ctrl      = '{stall: stall, flush: flush};
  assign adv       = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic             down;
  logic             up;
  logic             skid_valid;
  logic             skid_load;
  logic             skid_unload;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_valid & !ctrl.stall
                  & !ctrl.flush & !rst;
  assign down = valid_q & out_ready
              & !ctrl.stall & !ctrl.flush;
  assign up   = in_valid & in_ready;

  // Park only when main is full and not draining.
  assign skid_load   = up & valid_q & !down;
  assign skid_unload = skid_valid & down;

  pipe_skid_slot #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (ctrl.flush),
    .load     (skid_load),
    .unload   (skid_unload),
    .load_data(in_data),
    .valid    (skid_valid),
    .data     (skid_data)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ctrl.flush) begin
      valid_d = 1'b0;
      data_d  = BUBBLE_VAL;
    end else if (ctrl.stall) begin
      valid_d = valid_q;
    end else if (skid_valid) begin
      // Older skid entry refills main first.
      if (down) begin
        valid_d = 1'b1;
        data_d  = skid_data;
      end
    end else if (adv) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end
`else
  assign in_ready = adv & !ctrl.stall
                  & !ctrl.flush & !rst;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ctrl.flush) begin
      valid_d = 1'b0;
      data_d  = BUBBLE_VAL;
    end else if (ctrl.stall) begin
      valid_d = valid_q;
    end else if (adv) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg.
// Reference model: an ordered queue with fixed capacity.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] RV = 32'hC0DE_0001;
  localparam logic [31:0] BV = NOP_INSTR;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];
  logic        idle_known = 1'b0;
  logic [31:0] idle_val = '0;

  pipe_stage_reg #(
    .WIDTH(32),
    .RESET_VAL(RV),
    .BUBBLE_VAL(BV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT to the queue model each cycle.
  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, RV);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        idle_known = 1'b1;
        idle_val = RV;
      end else begin
        exp_rdy = !stall && !flush &&
                  (exp_q.size() < CAP ||
                   (CAP == 1 && out_ready));
        chk("in_ready", {31'd0, in_ready},
            {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid},
            {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0)
          chk("out_data", out_data, exp_q[0]);
        else if (idle_known)
          chk("idle_data", out_data, idle_val);
        if (flush) begin
          exp_q.delete();
          idle_known = 1'b1;
          idle_val = BV;
        end else if (!stall && out_ready &&
                     exp_q.size() != 0) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus: one cycle of inputs; push accepted payloads.
  task automatic cyc(input logic r, input logic s,
                     input logic f, input logic iv,
                     input logic [31:0] d,
                     input logic ordy);
    @(negedge clk);
    rst = r;
    stall = s;
    flush = f;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #2;
    if (in_valid && in_ready && !rst) begin
      exp_q.push_back(in_data);
      idle_known = 1'b0;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // reset mid-transfer
    cyc(0, 0, 0, 1, 32'h1234_5678, 0);
    cyc(1, 0, 0, 1, 32'hDEAD_BEEF, 1);
    cyc(0, 0, 0, 0, 32'hDEAD_BEEF, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // back-to-back stream
    cyc(0, 0, 0, 1, 32'h1, 1);
    cyc(0, 0, 0, 1, 32'h2, 1);
    cyc(0, 0, 0, 1, 32'h3, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // stall hold
    cyc(0, 0, 0, 1, 32'hA5, 0);
    repeat (3) cyc(0, 1, 0, 1, 32'h5A, 1);
    cyc(0, 0, 0, 1, 32'h5A, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // flush beats stall
    cyc(0, 0, 0, 1, 32'h77, 0);
    cyc(0, 1, 1, 1, 32'h99, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // fill main and skid, then drain
    cyc(0, 0, 0, 1, 32'h10, 0);
    cyc(0, 0, 0, 1, 32'h11, 0);
    cyc(0, 0, 0, 1, 32'h12, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // random, no flush
    for (int i = 0; i < 10000; i++)
      cyc(0, $urandom_range(3) == 0, 0,
          $urandom_range(1) == 1, $urandom,
          $urandom_range(1) == 1);

    // random with occasional flush
    for (int i = 0; i < 2000; i++)
      cyc(0, $urandom_range(3) == 0,
          $urandom_range(15) == 0,
          $urandom_range(1) == 1, $urandom,
          $urandom_range(1) == 1);

    // bounded drain
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("drain", exp_q.size(), 32'd0);
    cyc(0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
